// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline writeback, load-return and register-file write-port signals
// around the write-port arbiter.
interface wb_port_arbiter_if #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned ASIZE = 5,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             wb_valid;
    logic [ASIZE-1:0] wb_addr;
    logic [DSIZE-1:0] wb_data;

    logic             ld_valid;
    logic             ld_ready;
    logic [ASIZE-1:0] ld_addr;
    logic [DSIZE-1:0] ld_data;

    logic             rf_we;
    logic [ASIZE-1:0] rf_waddr;
    logic [DSIZE-1:0] rf_wdata;

    logic             stall_req;
    logic [CW-1:0]    pend_cnt;

    // Arbiter side
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req, pend_cnt
    );

    // Pipeline / load unit / register file side
    modport master (
        output wb_valid, wb_addr, wb_data,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req, pend_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, load
// returns queue in an in-order buffer and drain into idle cycles, starvation raises stall_req.
module wb_port_arbiter #(
    parameter int unsigned DSIZE        = 32,
    parameter int unsigned ASIZE        = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_port_arbiter_if.slave     bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic             v;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [ASIZE-1:0] rf_waddr_q, rf_waddr_d;
    logic [DSIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic             stall_q, stall_d;

    logic             wb_eff_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    logic             ld_ready_c;
    entry_t           head_c;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wb_eff_c   = bus.wb_valid && (bus.wb_addr != '0);
    assign empty_c    = (cnt_q == '0);
    assign ld_ready_c = (cnt_q < CW'(DEPTH));
    assign push_c     = bus.ld_valid && ld_ready_c;
    assign pop_c      = !wb_eff_c && !empty_c;
    assign head_c     = fifo_q[rd_ptr_q];

    // Next-state: grant, squash, push, occupancy, starvation and stall
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        stall_d    = 1'b0;

        if (wb_eff_c) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_addr;
            rf_wdata_d = bus.wb_data;
            // Buffered loads are older than this write, so they must not land after it
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (fifo_q[i].addr == bus.wb_addr) begin
                    fifo_d[i].v = 1'b0;
                end
            end
        end else if (pop_c) begin
            rf_we_d  = head_c.v;
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head_c.v) begin
                rf_waddr_d = head_c.addr;
                rf_wdata_d = head_c.data;
            end
        end

        // Applied after squash so a same-cycle load is treated as younger
        if (push_c) begin
            fifo_d[wr_ptr_q].v    = (bus.ld_addr != '0);
            fifo_d[wr_ptr_q].addr = bus.ld_addr;
            fifo_d[wr_ptr_q].data = bus.ld_data;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end

        if (push_c && !pop_c) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (empty_c || pop_c) begin
            starve_d = '0;
        end else if (head_c.v && wb_eff_c && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        stall_d = !empty_c && !pop_c && (starve_q == SW'(STARVE_LIMIT));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.ld_ready  = ld_ready_c;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_req = stall_q;
    assign bus.pend_cnt  = cnt_q;
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the pipeline writeback path (output of the EXE/WB stage register) and a multi-cycle load-return path. Pipeline writes have absolute priority and are never delayed. Load returns are held in a small in-order pending buffer and drained into idle write-port cycles. A starvation counter raises a stall request toward the pipeline front end so that buffered loads are guaranteed to retire.

## Interface
- DSIZE, 32: data width of the register-file write port.
- ASIZE, 5: register address width. Address 0 is hardwired zero.
- DEPTH, 2: pending load-buffer entries, must be 2 or more.
- STARVE_LIMIT, 4: consecutive starved cycles before `stall_req` asserts.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback valid, from the EXE/WB register output.
- wb_addr  in  ASIZE  pipeline writeback address.
- wb_data  in  DSIZE  pipeline writeback data.
- ld_valid  in  1  load-return request.
- ld_ready  out  1  load-return accept; a transfer occurs when `ld_valid` and `ld_ready` are both high.
- ld_addr  in  ASIZE  load destination register.
- ld_data  in  DSIZE  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ASIZE  register-file write address (registered).
- rf_wdata  out  DSIZE  register-file write data (registered).
- stall_req  out  1  request to the front end to inject a bubble (registered).
- pend_cnt  out  $clog2(DEPTH+1)  number of occupied buffer entries.

## Operation
- **Effective pipeline write.** A pipeline write is effective when `wb_valid` is high and `wb_addr` is not 0. A write to address 0 is dropped and does not use the port.
- **Load accept.** `ld_ready` equals `pend_cnt < DEPTH`. It is combinational from registered state only and never depends on `ld_valid`. An accepted load is pushed at the FIFO tail with its entry-valid bit set to `ld_addr != 0`. A load never bypasses the buffer.
- **Port grant, per cycle, in priority order.**
  1. An effective pipeline write wins. Next cycle `rf_we=1` and `rf_waddr/rf_wdata` equal `wb_addr/wb_data`.
  2. Otherwise, if the buffer is non-empty, the head is popped. If its valid bit is set, next cycle `rf_we=1` with the head's address and data. If the bit is clear, next cycle `rf_we=0`; the entry is a silent discard.
  3. Otherwise, next cycle `rf_we=0`. `rf_waddr` and `rf_wdata` hold their previous values.
- **Squash (write-after-write ordering).**
  - An effective pipeline write to address X clears the valid bit of every entry already in the buffer whose address is X. Buffered entries are older than the concurrent pipeline write.
  - A load pushed in the same cycle counts as younger and is not squashed.
- **Simultaneous push and pop** in the same cycle is allowed. `pend_cnt` is unchanged in that case.
- **Starvation counter `starve_cnt`.**
  - Increments each cycle the buffer head is valid and an effective pipeline write takes the port.
  - Clears when the head is popped or the buffer is empty.
  - Saturates at `STARVE_LIMIT`.
- **Stall request.** `stall_req` is registered. It is 1 while `starve_cnt == STARVE_LIMIT` and the head has not yet been popped. It drops the cycle after the pop. The front end guarantees a bubble (`wb_valid=0`) at this block's input within a bounded number of cycles; this block does not drop pipeline writes.

## Timing
- **Reset** (`rst` low, asynchronous):
  - Outputs: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `stall_req=0`, `pend_cnt=0`, so `ld_ready=1`.
  - Internal state: all valid bits clear, FIFO pointers and `starve_cnt` at 0.
  - Reset asserted mid-operation discards all buffered loads with no write.
- **Latency:**
  - Pipeline write: 1 cycle, from input edge to `rf_we`.
  - Load: at least 2 cycles. The load is accepted at edge N, becomes the head, and `rf_we` rises at edge N+2 if the port is idle in cycle N+1.
- **Throughput and ordering:**
  - At most one register-file write per cycle.
  - Loads retire in accept order.
  - Pointers wrap modulo DEPTH.
- **Stall timing:** `stall_req` rises the cycle after `starve_cnt` reaches `STARVE_LIMIT`.

## Test plan
- **Reset.** Reset with `ld_valid=1` and `wb_valid=1` held → all outputs 0 and `ld_ready=1`. After reset release, `wb_valid=1, wb_addr=3, wb_data=0xA5` → next cycle `rf_we=1, rf_waddr=3, rf_wdata=0xA5`.
- **Idle-port load.** Load `addr=7, data=0x11` with the pipeline idle → `pend_cnt=1` after accept. `rf_we=1, waddr=7, wdata=0x11` two cycles after accept, then `pend_cnt=0`.
- **Buffer full.** Pipeline writes every cycle; push loads to addresses 4 and 5 → `pend_cnt=2` and `ld_ready=0`. A third `ld_valid` is held off. `pend_cnt` stays at 2.
- **Starvation.** Continue the full-buffer scenario for 4 pipeline-write cycles → `stall_req=1`. Drop `wb_valid` for one cycle → the addr-4 load is written, and `stall_req=0` the following cycle.
- **Squash.** Buffer a load to addr 9, then a pipeline write to 9 (data `0x22`) → `rf_wdata=0x22` at addr 9. The buffered entry is popped silently (`rf_we=0` in that cycle). No later write to 9 occurs.
- **Address 0 dropped.** `wb_addr=0` with `wb_valid=1` and a buffered valid head → the head is written that cycle. A load to addr 0 is accepted and discarded with no `rf_we`.
